ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 13 +
 rtl/ccff_readback_deser.sv | 71 +++++++
 rtl/ccff_loader.sv | 131 +++++++++++++
 tb/tb_ccff_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM encoding and bit-counter width.
package ccff_pkg;

  localparam int CNT_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/ccff_readback_deser.sv
// Packs the bits returned from the chain tail into readback words and holds one word
// for the consumer, asking the loader to pause shifting while that word is unread.
module ccff_readback_deser
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample,
  input  logic              tail,
  input  logic              final_bit,
  input  logic              next_final,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              stall
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] acc, acc_n, m_data_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              m_valid_n, complete;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_n     = acc;
    idx_n     = idx;
    m_data_n  = m_data;
    m_valid_n = m_valid && !m_ready;
    complete  = sample && ((idx == LAST_IDX) || final_bit);
    if (sample) begin
      acc_n = acc | (WORD_W'(tail) << idx);
      idx_n = idx + IDX_W'(1);
    end
    if (complete) begin
      // A partial final word is already zero above the sampled bits.
      m_data_n  = acc_n;
      m_valid_n = 1'b1;
      acc_n     = '0;
      idx_n     = '0;
    end
    if (clear) begin
      acc_n     = '0;
      idx_n     = '0;
      m_data_n  = '0;
      m_valid_n = 1'b0;
    end
    // Pause while the slot stays occupied, and never let a shift complete a word into a full slot.
    stall = m_valid_n && (!m_ready || (idx_n == LAST_IDX) || next_final);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      acc     <= acc_n;
      idx     <= idx_n;
      m_valid <= m_valid_n;
      m_data  <= m_data_n;
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Streams bitstream words LSB first into a configuration flip-flop chain while reading
// the previous chain contents back out as words; flags length mismatches as errors.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 6,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_M1   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(WORD_W);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [WORD_W-1:0] wbuf, wbuf_n;
  logic [IDX_W-1:0]  bidx, bidx_n;
  logic              wfull, wfull_n, last_seen, last_seen_n;
  logic              shift_n, head_n;
  logic              last_chain, drain, accept, clear, stall;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    wbuf_n      = wbuf;
    bidx_n      = bidx;
    wfull_n     = wfull;
    last_seen_n = last_seen;
    last_chain  = (cnt == LEN_M1);
    drain       = shift_en && ((bidx == LAST_IDX) || last_chain);
    // A new word is taken only if it can still land in the chain.
    s_ready     = (state == LOAD) && !last_seen && (!wfull || (drain && !last_chain));
    accept      = s_valid && s_ready;

    unique case (state)
      IDLE, ERR: begin
        if (start) begin
          state_n     = LOAD;
          cnt_n       = '0;
          wbuf_n      = '0;
          bidx_n      = '0;
          wfull_n     = 1'b0;
          last_seen_n = 1'b0;
        end
      end
      LOAD: begin
        if (shift_en) cnt_n = cnt + CNT_W'(1);
        if (accept) begin
          wbuf_n      = s_data;
          bidx_n      = '0;
          wfull_n     = 1'b1;
          last_seen_n = s_last;
        end else if (drain) begin
          wfull_n = 1'b0;
        end else if (shift_en) begin
          bidx_n = bidx + IDX_W'(1);
        end

        if (accept && s_last && ((cnt_n + WORD_LEN) < LEN)) state_n = ERR;
        else if (shift_en && last_chain && !last_seen)      state_n = ERR;
        else if ((cnt == LEN) && m_valid && m_ready)        state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    clear   = (state != LOAD) || (state_n != LOAD);
    shift_n = (state_n == LOAD) && wfull_n && (cnt_n < LEN) && !stall;
    head_n  = shift_n && wbuf_n[bidx_n];
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state     <= IDLE;
      cnt       <= '0;
      wbuf      <= '0;
      bidx      <= '0;
      wfull     <= 1'b0;
      last_seen <= 1'b0;
      shift_en  <= 1'b0;
      ccff_head <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wbuf      <= wbuf_n;
      bidx      <= bidx_n;
      wfull     <= wfull_n;
      last_seen <= last_seen_n;
      shift_en  <= shift_n;
      ccff_head <= head_n;
    end
  end

  ccff_readback_deser #(.WORD_W(WORD_W)) u_deser (
    .clk        (prog_clk),
    .rst_n      (pReset),
    .clear      (clear),
    .sample     (shift_en),
    .tail       (ccff_tail),
    .final_bit  (last_chain),
    .next_final (cnt_n == LEN_M1),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .stall      (stall)
  );

  assign busy = (state == LOAD) || (state == FIN);
  assign done = (state == FIN);
  assign err  = (state == ERR);

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader (CHAIN_LEN=6, WORD_W=4) with a behavioural 6-bit chain.
module tb_ccff_loader;

  logic       prog_clk = 1'b0;
  logic       pReset, start, s_valid, s_last, m_ready;
  logic [3:0] s_data;
  logic       s_ready, ccff_head, shift_en, ccff_tail, m_valid, busy, done, err;
  logic [3:0] m_data;

  ccff_loader #(.CHAIN_LEN(6), .WORD_W(4)) dut (
    .prog_clk (prog_clk), .pReset (pReset), .start (start),
    .s_valid  (s_valid),  .s_data (s_data), .s_last (s_last), .s_ready (s_ready),
    .ccff_head(ccff_head), .shift_en(shift_en), .ccff_tail(ccff_tail),
    .m_valid  (m_valid),  .m_data (m_data), .m_ready(m_ready),
    .busy     (busy),     .done   (done),   .err    (err)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: head enters bit 0, oldest bit leaves at bit 5.
  logic [5:0] chain = '0;
  logic [5:0] preset_val = '0;
  logic       preset_req = 1'b0;
  assign ccff_tail = chain[5];
  always @(posedge prog_clk) begin
    if (preset_req)    chain <= preset_val;
    else if (shift_en) chain <= {chain[4:0], ccff_head};
  end

  // Monitor samples on the falling edge what the next rising edge will act on.
  int         shift_cnt = 0, done_cnt = 0, rd_n = 0;
  logic [5:0] head_seq = '0;
  logic [3:0] rd [8];
  logic       mon_clr = 1'b0;
  always @(negedge prog_clk) begin
    if (mon_clr) begin
      shift_cnt = 0; done_cnt = 0; rd_n = 0; head_seq = '0;
    end else if (pReset) begin
      if (shift_en) begin
        shift_cnt++;
        head_seq = {head_seq[4:0], ccff_head};
      end
      if (m_valid && m_ready && rd_n < 8) begin
        rd[rd_n] = m_data;
        rd_n++;
      end
      if (done) done_cnt++;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge prog_clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic preset_chain(input logic [5:0] v);
    preset_val = v;
    preset_req = 1'b1;
    @(posedge prog_clk);
    #1 preset_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge prog_clk);
    #1 start = 1'b1;
    @(posedge prog_clk);
    #1 start = 1'b0;
  endtask

  typedef struct {
    string      name;
    bit         preset_en;
    logic [5:0] preset;
    int         n_words;
    logic [11:0] words;     // word i at [4*i +: 4]
    logic [2:0] lasts;
    int         stall;      // m_ready=0 cycles once the first readback word shows
    int         exp_shifts;
    logic [5:0] exp_head;   // first head bit at MSB
    int         exp_rd_n;
    logic [3:0] exp_rd0;
    logic [3:0] exp_rd1;
    bit         exp_err;
    int         exp_done;
    int         exp_acc;
  } vec_t;

  vec_t tbl [4];

  task automatic run_load(input vec_t v);
    int  idx = 0, hold = 0, shifts_at_err = -1, stall_shifts = -1;
    bit  fin = 0, acc;
    mon_clear();
    if (v.preset_en) preset_chain(v.preset);
    m_ready = (v.stall == 0);
    pulse_start();
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      s_valid = (idx < v.n_words);
      s_data  = (idx < 3) ? v.words[4*idx +: 4] : 4'h0;
      s_last  = (idx < 3) ? v.lasts[idx] : 1'b0;
      @(negedge prog_clk);
      #1;
      acc = s_valid && s_ready;
      if (err && shifts_at_err < 0) shifts_at_err = shift_cnt;
      if (done_cnt > 0 || err) fin = 1;
      @(posedge prog_clk);
      #1;
      if (acc) idx++;
      if (!m_ready) begin
        if (m_valid) hold++;
        if (hold >= v.stall) begin
          stall_shifts = shift_cnt;
          m_ready = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge prog_clk);
    #1;
    check({v.name, "_finished"}, 32'(fin), 1);
    check({v.name, "_shifts"}, shift_cnt, v.exp_shifts);
    check({v.name, "_heads"}, head_seq, v.exp_head);
    check({v.name, "_chain"}, chain, v.exp_head);
    check({v.name, "_rd_count"}, rd_n, v.exp_rd_n);
    if (v.exp_rd_n > 0) check({v.name, "_rd0"}, rd[0], v.exp_rd0);
    if (v.exp_rd_n > 1) check({v.name, "_rd1"}, rd[1], v.exp_rd1);
    check({v.name, "_err"}, err, v.exp_err);
    check({v.name, "_done_pulses"}, done_cnt, v.exp_done);
    check({v.name, "_accepted"}, idx, v.exp_acc);
    check({v.name, "_busy"}, busy, 0);
    if (v.stall > 0) check({v.name, "_stall_shifts"}, stall_shifts, 4);
    if (v.exp_err)   check({v.name, "_shifts_at_err"}, shifts_at_err, v.exp_shifts);
  endtask

  initial begin
    int  n;
    bit  seen;
    tbl[0] = '{"t1_zero_chain", 1'b1, 6'b000000, 2, 12'h03A, 3'b010, 0, 6, 6'b010111, 2, 4'h0, 4'h0, 1'b0, 1, 2};
    tbl[1] = '{"t2_reload",     1'b0, 6'b000000, 2, 12'h005, 3'b010, 0, 6, 6'b101000, 2, 4'hA, 4'h3, 1'b0, 1, 2};
    tbl[2] = '{"t3_backpress",  1'b1, 6'b010111, 2, 12'h005, 3'b010, 10, 6, 6'b101000, 2, 4'hA, 4'h3, 1'b0, 1, 2};
    tbl[3] = '{"t6_no_last",    1'b1, 6'b000000, 3, 12'h421, 3'b000, 0, 6, 6'b100001, 1, 4'h0, 4'h0, 1'b1, 0, 2};

    pReset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1;
    check("reset_outputs", {ccff_head, shift_en, s_ready, m_valid, m_data, busy, done, err}, 0);
    @(negedge prog_clk);
    pReset = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;
    check("idle_waits_for_start", {busy, shift_en, s_ready}, 0);

    for (int r = 0; r < 3; r++) run_load(tbl[r]);

    // Test 4: a lone last word cannot fill the chain.
    mon_clear();
    pulse_start();
    s_valid = 1'b1; s_data = 4'hF; s_last = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge prog_clk);
      #1 seen = err;
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("t4_err_set", err, 1);
    check("t4_not_busy", busy, 0);
    check("t4_no_ready", s_ready, 0);
    repeat (5) @(posedge prog_clk);
    #1;
    check("t4_no_shifts", shift_cnt, 0);
    check("t4_err_sticky", {err, shift_en, m_valid}, 3'b100);
    pulse_start();
    check("t4_start_clears_err", {err, busy}, 2'b01);

    // Test 5: reset after three shifts.
    mon_clear();
    s_valid = 1'b1; s_data = 4'h5; s_last = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge prog_clk);
      #1 n = shift_cnt;
    end
    check("t5_reached_three", n, 3);
    @(posedge prog_clk);
    #1 pReset = 1'b0;
    #1;
    check("t5_reset_outputs", {ccff_head, shift_en, s_ready, m_valid, m_data, busy, done, err}, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1 pReset = 1'b1;
    repeat (10) @(posedge prog_clk);
    #1;
    check("t5_no_shift_after_reset", shift_cnt, 3);
    check("t5_idle", {busy, shift_en}, 0);

    run_load(tbl[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
